// File: rtl/bg_noise_calc_pkg.sv
// Shared constants and lane-indexing helpers for the background-noise accumulator.
package bg_noise_calc_pkg;

  localparam int unsigned LANES    = 16;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned NOISE_W  = 16;

  localparam int unsigned SAMPLE_BUS_W = LANES * SAMPLE_W;
  localparam int unsigned NOISE_BUS_W  = LANES * NOISE_W;

  // Saturation limits of one signed noise estimate
  localparam int NOISE_MAX = (1 << (NOISE_W - 1)) - 1;
  localparam int NOISE_MIN = -(1 << (NOISE_W - 1));

  // Bit offset of lane i within the packed sample bus
  function automatic int unsigned sample_lsb(input int unsigned lane);
    return SAMPLE_W * lane;
  endfunction

  // Bit offset of lane i within the packed noise bus
  function automatic int unsigned noise_lsb(input int unsigned lane);
    return NOISE_W * lane;
  endfunction

endpackage

// File: rtl/bg_noise_lane.sv
// One lane: sign-extend sample and noise, add, saturate to the noise range.
module bg_noise_lane
  import bg_noise_calc_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [NOISE_W-1:0]  cur_noise,
  output logic [NOISE_W-1:0]  sum_c
);

  // One guard bit is enough: |sample| is far below 2^(NOISE_W-1)
  localparam int unsigned SUM_W = NOISE_W + 1;

  logic [SUM_W-1:0] sum_ext;

  // Full-precision two's complement sum, then clamp when the guard bit disagrees
  always_comb begin
    sum_ext = {{(SUM_W - SAMPLE_W){sample[SAMPLE_W-1]}}, sample}
            + {cur_noise[NOISE_W-1], cur_noise};
    sum_c   = sum_ext[NOISE_W-1:0];
    if (sum_ext[SUM_W-1] != sum_ext[SUM_W-2]) begin
      sum_c = sum_ext[SUM_W-1] ? NOISE_W'(NOISE_MIN) : NOISE_W'(NOISE_MAX);
    end
  end

endmodule

// File: rtl/bg_noise_calc.sv
// Per-lane background-noise accumulator: one registered saturated update per valid cycle.
module bg_noise_calc
  import bg_noise_calc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [SAMPLE_BUS_W-1:0] period_data,
  input  logic [NOISE_BUS_W-1:0]  cur_noise,
  output logic                    out_valid,
  output logic [NOISE_BUS_W-1:0]  updated_noise
);

  logic [NOISE_BUS_W-1:0] sum_c;

  // Independent saturating adder per lane
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    bg_noise_lane u_lane (
      .sample    (period_data[SAMPLE_W*i +: SAMPLE_W]),
      .cur_noise (cur_noise[NOISE_W*i +: NOISE_W]),
      .sum_c     (sum_c[NOISE_W*i +: NOISE_W])
    );
  end

  // Result register loads only on valid; out_valid marks the cycle after a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      updated_noise <= '0;
      out_valid     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        updated_noise <= sum_c;
      end
    end
  end

endmodule

// File: tb/tb_bg_noise_calc.sv
// Randomized self-checking bench for bg_noise_calc against a plain-integer model.
module tb_bg_noise_calc;
  import bg_noise_calc_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic [SAMPLE_BUS_W-1:0] period_data;
  logic [NOISE_BUS_W-1:0]  cur_noise;
  logic                    out_valid;
  logic [NOISE_BUS_W-1:0]  updated_noise;

  int n_checks = 0;
  int n_pass   = 0;

  int smp   [LANES];
  int cur   [LANES];
  int exp_n [LANES];
  bit exp_v;

  bg_noise_calc dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .period_data   (period_data),
    .cur_noise     (cur_noise),
    .out_valid     (out_valid),
    .updated_noise (updated_noise)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int clamp(input int s);
    if (s > NOISE_MAX) return NOISE_MAX;
    if (s < NOISE_MIN) return NOISE_MIN;
    return s;
  endfunction

  function automatic int lane_out(input int i);
    logic signed [NOISE_W-1:0] v;
    v = updated_noise[noise_lsb(i) +: NOISE_W];
    return int'(v);
  endfunction

  task automatic drive_inputs(input bit v);
    in_valid = v;
    for (int i = 0; i < int'(LANES); i++) begin
      period_data[sample_lsb(i) +: SAMPLE_W] = SAMPLE_W'(smp[i]);
      cur_noise[noise_lsb(i) +: NOISE_W]     = NOISE_W'(cur[i]);
    end
  endtask

  task automatic model_step(input bit v);
    exp_v = v;
    if (v) begin
      for (int i = 0; i < int'(LANES); i++) exp_n[i] = clamp(smp[i] + cur[i]);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'(exp_v));
    for (int i = 0; i < int'(LANES); i++) begin
      check($sformatf("%s.lane%0d", tag, i), 64'(lane_out(i)), 64'(exp_n[i]));
    end
  endtask

  // Called at a negedge: apply inputs, clock once, compare, return at next negedge
  task automatic cycle(input bit v, input string tag);
    drive_inputs(v);
    @(posedge clk);
    #1;
    model_step(v);
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < int'(LANES); i++) begin
      smp[i] = int'($urandom_range(0, 255)) - 128;
      case ($urandom_range(0, 3))
        0:       cur[i] = NOISE_MAX - int'($urandom_range(0, 127));
        1:       cur[i] = NOISE_MIN + int'($urandom_range(0, 127));
        default: cur[i] = int'($urandom_range(0, 65535)) - 32768;
      endcase
    end
  endtask

  task automatic reset_model();
    exp_v = 1'b0;
    for (int i = 0; i < int'(LANES); i++) exp_n[i] = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    period_data = '0;
    cur_noise   = '0;
    reset_model();
    #1;
    check_outputs("reset_init");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp: lane i = -i + 100*i
    for (int i = 0; i < int'(LANES); i++) begin
      smp[i] = -i;
      cur[i] = i * 100;
    end
    cycle(1'b1, "ramp");
    check("ramp.lane15_const", 64'(lane_out(15)), 64'(1485));
    rand_inputs();
    cycle(1'b0, "ramp_hold");

    // Saturation corners on lanes 0..3, random elsewhere
    rand_inputs();
    cur[0] = 32767;  smp[0] = 127;
    cur[1] = -32768; smp[1] = -128;
    cur[2] = 32700;  smp[2] = 67;
    cur[3] = -32700; smp[3] = -68;
    cycle(1'b1, "sat");
    check("sat.lane0_const", 64'(lane_out(0)), 64'(32767));
    check("sat.lane1_const", 64'(lane_out(1)), 64'(-32768));
    check("sat.lane2_const", 64'(lane_out(2)), 64'(32767));
    check("sat.lane3_const", 64'(lane_out(3)), 64'(-32768));

    // Lane isolation: only lane 7 driven to saturation
    for (int i = 0; i < int'(LANES); i++) begin
      smp[i] = 0;
      cur[i] = 0;
    end
    cur[7] = 32767;
    smp[7] = 127;
    cycle(1'b1, "iso");
    begin
      logic [NOISE_BUS_W-1:0] iso_vec;
      iso_vec = '0;
      iso_vec[noise_lsb(7) +: NOISE_W] = 16'h7fff;
      check("iso.bus_hi", 64'(updated_noise[255:128]), 64'(iso_vec[255:128]));
      check("iso.bus_lo", 64'(updated_noise[127:0]  ), 64'(iso_vec[127:0]));
    end

    // Streaming with feedback: 5, 10, 15, 20 with in_valid held high
    for (int i = 0; i < int'(LANES); i++) begin
      smp[i] = 5;
      cur[i] = 0;
    end
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, $sformatf("stream%0d", k));
      check($sformatf("stream%0d.lane0_const", k), 64'(lane_out(0)), 64'(5 * k));
      for (int i = 0; i < int'(LANES); i++) cur[i] = lane_out(i);
    end

    // Hold: random inputs with in_valid low
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      cycle(1'b0, $sformatf("hold%0d", k));
    end

    // Random mix of valid and idle cycles
    for (int k = 0; k < 40; k++) begin
      rand_inputs();
      cycle(1'($urandom_range(0, 2) != 0), $sformatf("rand%0d", k));
    end

    // Mid-stream reset: make outputs nonzero, then reset between edges
    rand_inputs();
    cycle(1'b1, "pre_rst");
    rand_inputs();
    drive_inputs(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    rand_inputs();
    cycle(1'b1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bg_noise_calc.md
Name: bg_noise_calc

Overview:
- Per-lane background-noise accumulator for the detection pipeline.
- Each valid cycle it adds one period's vector of signed 8-bit samples, lane by lane, to the current vector of signed 16-bit noise estimates.
- It registers the updated noise vector.
- It sits between the period-data capture stage and the noise-estimate store. The store feeds the result back as the next current noise.

Parameters:
- LANES, 16, number of independent lanes.
- SAMPLE_W, 8, width of one signed period-data sample.
- NOISE_W, 16, width of one signed noise estimate; must be greater than SAMPLE_W.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  period_data and cur_noise are valid this cycle.
- period_data  input  LANES*SAMPLE_W (128)  packed signed samples; lane i at bits [SAMPLE_W*i +: SAMPLE_W].
- cur_noise  input  LANES*NOISE_W (256)  packed signed current noise; lane i at bits [NOISE_W*i +: NOISE_W].
- out_valid  output  1  updated_noise holds a new result.
- updated_noise  output  LANES*NOISE_W (256)  packed signed updated noise, same lane layout as cur_noise.

Behaviour:
- Reset: while rst_n=0, updated_noise=0 and out_valid=0, taking effect immediately. Release is synchronous to clk by the surrounding design.
- Lane arithmetic is two's complement. For each lane:
  - sum = sign_extend(period_data lane, NOISE_W+1) + sign_extend(cur_noise lane, NOISE_W+1).
  - The result is saturated to the NOISE_W signed range: max 32767, min -32768 for defaults.
- Lanes are fully independent; there is no carry or saturation interaction between them.
- Latency is 1 cycle. On a rising clk edge with in_valid=1:
  - every lane of updated_noise is loaded with its saturated sum;
  - out_valid is set to 1 for exactly that following cycle.
- On a rising edge with in_valid=0: updated_noise holds its previous value and out_valid goes to 0.
- Back-to-back in_valid is supported at one result per cycle, with no stall and no ready signal.
- Inputs are sampled only at clock edges. Input changes between edges have no effect.
- If reset is asserted mid-stream, any in-flight result is discarded and outputs return to 0 immediately.
- There is no internal state other than the output register and out_valid.

Decomposition:
- Shared package holds:
  - the LANES, SAMPLE_W and NOISE_W constants;
  - NOISE_MAX and NOISE_MIN, derived as 2^(NOISE_W-1)-1 and -2^(NOISE_W-1);
  - lane slice helper functions or localparams for packed-vector indexing.
- One sub-module is natural: bg_noise_lane. It is combinational: sign-extend, add, saturate one lane. It is instantiated LANES times in a generate loop.
- The top module owns the registers and out_valid.

Test Plan:
- Reset: assert rst_n=0 mid-operation with outputs nonzero -> updated_noise=0 and out_valid=0 immediately, without waiting for a clk edge.
- Basic ramp:
  - stimulus: lane i period_data=-i, cur_noise=i*100, one in_valid pulse;
  - response: one cycle later out_valid=1 and lane i = 99*i (lane 0=0, lane 1=99, lane 15=1485).
  - on the next cycle out_valid=0 and the values hold.
- Saturation:
  - lane 0: cur=32767, sample=127 -> 32767;
  - lane 1: cur=-32768, sample=-128 -> -32768;
  - lane 2: cur=32700, sample=67 -> 32767;
  - lane 3: cur=-32700, sample=-68 -> -32768;
  - all other lanes unaffected.
- Lane isolation: all lanes cur=0, sample=0 except lane 7 cur=32767, sample=127 -> lane 7 = 32767, every other lane = 0, and no neighbour bits corrupted.
- Streaming feedback:
  - stimulus: drive in_valid=1 for 4 consecutive cycles with cur_noise fed back from updated_noise (initial 0) and all samples=5;
  - response: results 5, 10, 15, 20 on consecutive cycles and out_valid held at 1.
- Hold behaviour: after a result, in_valid=0 for 3 cycles while the inputs change randomly -> updated_noise unchanged and out_valid=0.
